// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the instruction and data SRAM-like request
// channels onto one memory port. An in-order ownership FIFO records which
// side issued each accepted request so responses are routed back correctly.
//
// Handshake: a request transfers on a cycle where mem_req & mem_addr_ok are
// both high; the granted side sees <x>_addr_ok in that same cycle. A response
// transfers on any cycle with mem_data_ok high and belongs to the oldest
// unanswered request.
module sram_like_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inst_req,
  input  logic                       inst_wr,
  input  logic [1:0]                 inst_size,
  input  logic [3:0]                 inst_wstrb,
  input  logic [31:0]                inst_addr,
  input  logic [31:0]                inst_wdata,
  output logic                       inst_addr_ok,
  output logic                       inst_data_ok,
  output logic [31:0]                inst_rdata,
  input  logic                       data_req,
  input  logic                       data_wr,
  input  logic [1:0]                 data_size,
  input  logic [3:0]                 data_wstrb,
  input  logic [31:0]                data_addr,
  input  logic [31:0]                data_wdata,
  output logic                       data_addr_ok,
  output logic                       data_data_ok,
  output logic [31:0]                data_rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [3:0]                 mem_wstrb,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic          hold_id, hold_id_nxt;   // 0 = inst, 1 = data
  logic          granted, grant_id, sel_req;
  logic          full, empty, accept, pop, head_id;
  logic          own_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head_id = own_q[rd_ptr];

  // Grant selection: a held grant is sticky, otherwise data beats inst.
  always_comb begin
    granted  = 1'b0;
    grant_id = 1'b0;
    if (state == HOLD) begin
      granted  = 1'b1;
      grant_id = hold_id;
    end else if (data_req) begin
      granted  = 1'b1;
      grant_id = 1'b1;
    end else if (inst_req) begin
      granted  = 1'b1;
      grant_id = 1'b0;
    end
  end

  assign sel_req = grant_id ? data_req : inst_req;
  assign mem_req = granted & sel_req & ~full & ~reset;
  assign accept  = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & ~empty & ~reset;

  // Request field mux of the granted side; zero with no grant or in reset.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (granted && !reset) begin
      if (grant_id) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  // Handshake and response routing back to the owning side.
  always_comb begin
    inst_addr_ok = accept & ~grant_id;
    data_addr_ok = accept &  grant_id;
    inst_data_ok = pop & ~head_id;
    data_data_ok = pop &  head_id;
    inst_rdata   = (pop && !head_id) ? mem_rdata : 32'd0;
    data_rdata   = (pop &&  head_id) ? mem_rdata : 32'd0;
  end

  // Grant FSM next state: stall in IDLE enters HOLD; HOLD leaves on accept
  // or when the held requester withdraws. A full FIFO leaves state as is.
  always_comb begin
    state_nxt   = state;
    hold_id_nxt = hold_id;
    case (state)
      IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_nxt   = HOLD;
          hold_id_nxt = grant_id;
        end
      end
      HOLD: begin
        if (!sel_req || accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hold_id <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold_id <= hold_id_nxt;
    end
  end

  // Ownership FIFO: push granted id on accept, pop head on response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) own_q[i] <= 1'b0;
    end else begin
      if (accept) begin
        own_q[wr_ptr] <= grant_id;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  // Sticky flag for a response that has no matching request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     resp_err <= 1'b0;
    else if (mem_data_ok && empty) resp_err <= 1'b1;
  end

  assign outstanding = count;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with hand-computed expectations.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outstanding;
  logic        resp_err;

  int n_cmp = 0;
  int n_err = 0;

  sram_like_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  // Clock: 10 time-unit period, posedges at 5, 15, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 0;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    data_req = 1; data_addr = 32'h1234_5678; mem_addr_ok = 1;
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_outstanding", {29'd0, outstanding}, 0);
    chk("rst_resp_err", {31'd0, resp_err}, 0);
    idle_inputs();
    tick(); tick();
    reset = 0;
    tick();

    // Single data read.
    data_req = 1; data_addr = 32'h1C00_0004; mem_addr_ok = 1;
    #1;
    chk("t1_mem_req", {31'd0, mem_req}, 1);
    chk("t1_mem_addr", mem_addr, 32'h1C00_0004);
    chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 1);
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 0);
    tick();
    idle_inputs();
    chk("t1_outstanding1", {29'd0, outstanding}, 1);
    tick();
    mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_data_data_ok", {31'd0, data_data_ok}, 1);
    chk("t1_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 0);
    chk("t1_inst_rdata", inst_rdata, 0);
    tick();
    idle_inputs();
    chk("t1_outstanding0", {29'd0, outstanding}, 0);

    // Simultaneous requests: data first, inst next.
    inst_req = 1; inst_addr = 32'h0000_00A0;
    data_req = 1; data_addr = 32'h0000_00D0; data_wr = 1; data_wdata = 32'h55; data_wstrb = 4'hF;
    mem_addr_ok = 1;
    #1;
    chk("t2_mem_addr_d", mem_addr, 32'hD0);
    chk("t2_mem_wr", {31'd0, mem_wr}, 1);
    chk("t2_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
    chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 1);
    chk("t2_inst_addr_ok0", {31'd0, inst_addr_ok}, 0);
    tick();
    data_req = 0;
    #1;
    chk("t2_mem_addr_i", mem_addr, 32'hA0);
    chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
    chk("t2_outstanding1", {29'd0, outstanding}, 1);
    tick();
    idle_inputs();
    chk("t2_outstanding2", {29'd0, outstanding}, 2);
    mem_data_ok = 1; mem_rdata = 32'h11;
    #1;
    chk("t2_resp1_data", {31'd0, data_data_ok}, 1);
    chk("t2_resp1_inst", {31'd0, inst_data_ok}, 0);
    tick();
    mem_rdata = 32'h22;
    #1;
    chk("t2_resp2_inst", {31'd0, inst_data_ok}, 1);
    chk("t2_resp2_rdata", inst_rdata, 32'h22);
    chk("t2_resp2_data", {31'd0, data_data_ok}, 0);
    tick();
    idle_inputs();
    chk("t2_outstanding0", {29'd0, outstanding}, 0);

    // Stalled inst request held against a later data request.
    inst_req = 1; inst_addr = 32'h100;
    #1;
    chk("t3_c1_addr", mem_addr, 32'h100);
    chk("t3_c1_addr_ok", {31'd0, inst_addr_ok}, 0);
    tick();
    data_req = 1; data_addr = 32'h200;
    #1;
    chk("t3_c2_addr", mem_addr, 32'h100);
    chk("t3_c2_data_addr_ok", {31'd0, data_addr_ok}, 0);
    tick();
    chk("t3_c3_addr", mem_addr, 32'h100);
    tick();
    mem_addr_ok = 1;
    #1;
    chk("t3_c4_addr", mem_addr, 32'h100);
    chk("t3_c4_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
    tick();
    inst_req = 0;
    #1;
    chk("t3_c5_addr", mem_addr, 32'h200);
    chk("t3_c5_data_addr_ok", {31'd0, data_addr_ok}, 1);
    tick();
    idle_inputs();
    chk("t3_outstanding2", {29'd0, outstanding}, 2);
    mem_data_ok = 1;
    #1;
    chk("t3_resp1_inst", {31'd0, inst_data_ok}, 1);
    tick();
    chk("t3_resp2_data", {31'd0, data_data_ok}, 1);
    tick();
    idle_inputs();
    chk("t3_outstanding0", {29'd0, outstanding}, 0);

    // Fill to DEPTH, then free one slot for the fifth request.
    inst_req = 1; inst_addr = 32'h300; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_fill_req%0d", i), {31'd0, mem_req}, 1);
      tick();
    end
    chk("t4_full_outstanding", {29'd0, outstanding}, 4);
    chk("t4_full_mem_req", {31'd0, mem_req}, 0);
    chk("t4_full_addr_ok", {31'd0, inst_addr_ok}, 0);
    mem_data_ok = 1; mem_rdata = 32'h77;
    #1;
    chk("t4_pop_inst_data_ok", {31'd0, inst_data_ok}, 1);
    chk("t4_pop_mem_req", {31'd0, mem_req}, 0);
    tick();
    mem_data_ok = 0;
    #1;
    chk("t4_after_pop_outstanding", {29'd0, outstanding}, 3);
    chk("t4_fifth_addr_ok", {31'd0, inst_addr_ok}, 1);
    tick();
    chk("t4_refull_outstanding", {29'd0, outstanding}, 4);
    inst_req = 0;
    mem_data_ok = 1;
    tick();
    chk("t4_drain_outstanding", {29'd0, outstanding}, 3);
    inst_req = 1; mem_addr_ok = 1;
    #1;
    chk("t4_pushpop_addr_ok", {31'd0, inst_addr_ok}, 1);
    chk("t4_pushpop_data_ok", {31'd0, inst_data_ok}, 1);
    tick();
    inst_req = 0;
    chk("t4_pushpop_outstanding", {29'd0, outstanding}, 3);
    tick(); tick(); tick();
    idle_inputs();
    chk("t4_empty_outstanding", {29'd0, outstanding}, 0);

    // Response with empty FIFO.
    mem_data_ok = 1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("t5_inst_data_ok", {31'd0, inst_data_ok}, 0);
    chk("t5_data_data_ok", {31'd0, data_data_ok}, 0);
    chk("t5_data_rdata", data_rdata, 0);
    tick();
    idle_inputs();
    chk("t5_resp_err", {31'd0, resp_err}, 1);
    tick(); tick();
    chk("t5_resp_err_sticky", {31'd0, resp_err}, 1);

    // Reset mid-cycle with three outstanding.
    data_req = 1; data_addr = 32'h400; mem_addr_ok = 1;
    tick(); tick(); tick();
    chk("t6_outstanding3", {29'd0, outstanding}, 3);
    mem_data_ok = 1;
    #1;
    reset = 1;
    #1;
    chk("t6_rst_outstanding", {29'd0, outstanding}, 0);
    chk("t6_rst_mem_req", {31'd0, mem_req}, 0);
    chk("t6_rst_data_addr_ok", {31'd0, data_addr_ok}, 0);
    chk("t6_rst_data_data_ok", {31'd0, data_data_ok}, 0);
    chk("t6_rst_resp_err", {31'd0, resp_err}, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    idle_inputs();
    tick();
    reset = 0;
    tick();
    mem_data_ok = 1;
    tick();
    mem_data_ok = 0;
    chk("t6_late_resp_err", {31'd0, resp_err}, 1);
    chk("t6_late_outstanding", {29'd0, outstanding}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
